uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter WORD_SIZE, default 8: data bits per frame; legal range 5..8.
REQ-002 Parameter CLKS_PER_BIT, default 868: clk_in cycles per serial bit; minimum 2.
REQ-003 Parameter PARITY_EN, default 0: 1 inserts an even-parity bit after the data bits.
REQ-004 clk_in  input  1  single free-running clock; every register is clocked on its rising edge.
REQ-005 rst_in  input  1  synchronous, active-high reset, sampled on the rising edge of clk_in.
REQ-006 txEn_in  input  1  transmitter enable; gates the start of new frames only.
REQ-007 fifoOutReady_in  input  1  upstream FIFO not-empty flag.
REQ-008 fifoData_in  input  WORD_SIZE  upstream FIFO registered read data, valid one cycle after the read strobe.
REQ-009 fifoReadEn_out  output  1  one-cycle read strobe to the upstream FIFO.
REQ-010 tx_out  output  1  serial line; idle high.
REQ-011 busy_out  output  1  high while in any state other than IDLE.
REQ-012 done_out  output  1  one-cycle pulse at the end of each frame's stop bit.

Function
REQ-013 FSM states SHALL be exactly IDLE, REQ, LOAD, START, DATA, PARITY, STOP.
REQ-014 IDLE: when txEn_in=1 and fifoOutReady_in=1 are sampled, go to REQ; otherwise stay, with tx_out=1.
REQ-015 REQ lasts one cycle with fifoReadEn_out=1; fifoReadEn_out SHALL be 0 in every other state.
REQ-016 LOAD lasts one cycle and captures fifoData_in into the shift register.
REQ-017 tx_out SHALL go low on the cycle after LOAD, i.e. 3 cycles after fifoOutReady_in is sampled high in IDLE.
REQ-018 START, each DATA bit, PARITY and STOP SHALL each hold tx_out for exactly CLKS_PER_BIT cycles.
REQ-019 Bit period timing uses a baud counter of width $clog2(CLKS_PER_BIT), cleared at each state entry; a bit ends when the counter equals CLKS_PER_BIT-1.
REQ-020 Data bits are sent LSB first; a bit index counter runs from 0 to WORD_SIZE-1, and DATA exits after index WORD_SIZE-1.
REQ-021 PARITY is entered only if PARITY_EN=1 and drives the XOR of the loaded word (even parity); when PARITY_EN=0, DATA goes directly to STOP.
REQ-022 STOP drives tx_out=1; on its last cycle done_out=1, and the next state is IDLE.
REQ-023 Frame length in cycles = CLKS_PER_BIT*(2+WORD_SIZE+PARITY_EN), measured from tx_out falling to the end of STOP.
REQ-024 Back-to-back frames: when the FIFO is still non-empty after STOP, idle-high gap = 3 cycles (IDLE, REQ, LOAD).
REQ-025 txEn_in deasserted mid-frame: the current frame completes unchanged, and no new REQ is issued.
REQ-026 fifoOutReady_in falling during REQ or LOAD is ignored; the captured word is transmitted.
REQ-027 tx_out SHALL be driven from a register (glitch-free).

Reset
REQ-028 While rst_in=1: state=IDLE, tx_out=1, fifoReadEn_out=0, busy_out=0, done_out=0, and all counters=0.
REQ-029 Reset asserted mid-frame aborts the frame; tx_out SHALL be 1 on the first cycle after the reset edge.
REQ-030 The shift register contents are don't-care after reset.

Structure
REQ-031 The FSM state enum type and the default baud constant SHALL reside in the shared package uart_pkg.
REQ-032 One sub-module, uart_baud_counter, SHALL be used: a parameterised counter with clear input and tick output, reused by the future receiver.
REQ-033 Target size is 150-250 lines of RTL.

Verification (CLKS_PER_BIT=4, WORD_SIZE=8, unless stated)
REQ-034 Reset, then hold fifoOutReady_in=0 for 100 cycles -> tx_out=1, busy_out=0, fifoReadEn_out never asserted.
REQ-035 One word 0xA5 (PARITY_EN=0) -> exactly one read strobe, tx_out low 3 cycles after ready, serial bits 0,1,0,1,0,0,1,0,1,1, each 4 cycles, done_out pulse at cycle 40.
REQ-036 PARITY_EN=1, word 0x07 -> parity bit = 1, frame = 44 cycles.
REQ-037 FIFO holding 3 words (0x00, 0xFF, 0x3C) -> three frames with 3-cycle gaps and three read strobes; decoded bytes match in order.
REQ-038 Reset pulsed during DATA bit 3 -> tx_out=1 the next cycle, busy_out=0, and no done_out pulse.
REQ-039 txEn_in dropped during START with the FIFO non-empty -> the frame completes, and no further fifoReadEn_out occurs.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types and constants (transmit FSM states, default
//               baud divisor) used by the transmitter and baud counter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // 100 MHz clock / 115200 baud, rounded
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } uart_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_counter.sv
`default_nettype none
// ============================================================================
// Module      : uart_baud_counter
// Description : Bit-period counter. Counts 0..CLKS_PER_BIT-1 and wraps; tick is
//               high on the last cycle of each bit period. clear holds it at 0
//               so the first period after clear is a full bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear,
    output logic [$clog2(CLKS_PER_BIT)-1:0] count,
    output logic                            tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    assign tick = (count == CNT_W'(CLKS_PER_BIT - 1));

    // Free-running bit counter, wrapping at the end of each bit period
    always_ff @(posedge clk) begin
        if (rst || clear || tick) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule : uart_baud_counter
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : UART transmitter fed from a FIFO with registered read data.
//               Frame: start bit, WORD_SIZE data bits LSB first, optional even
//               parity, one stop bit. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int WORD_SIZE    = 8,                    // legal 5..8
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT, // minimum 2
    parameter int PARITY_EN    = 0
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 txEn_in,
    input  logic                 fifoOutReady_in,
    input  logic [WORD_SIZE-1:0] fifoData_in,
    output logic                 fifoReadEn_out,
    output logic                 tx_out,
    output logic                 busy_out,
    output logic                 done_out
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(WORD_SIZE);

    uart_state_t          state;
    logic [WORD_SIZE-1:0] shift_reg;
    logic                 parity_bit;
    logic [IDX_W-1:0]     bit_idx;
    logic [CNT_W-1:0]     baud_count;
    logic                 baud_tick;
    logic                 baud_clear;

    // The counter is held at zero until the line leaves idle; after that every
    // state change coincides with a tick, so each timed state starts at zero.
    assign baud_clear = (state == IDLE) || (state == REQ) || (state == LOAD);

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk_in),
        .rst   (rst_in),
        .clear (baud_clear),
        .count (baud_count),
        .tick  (baud_tick)
    );

    // Frame sequencer; line and handshake outputs are registered here
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state          <= IDLE;
            tx_out         <= 1'b1;
            fifoReadEn_out <= 1'b0;
            busy_out       <= 1'b0;
            done_out       <= 1'b0;
            bit_idx        <= '0;
            parity_bit     <= 1'b0;
        end else begin
            fifoReadEn_out <= 1'b0;
            done_out       <= 1'b0;
            case (state)
                IDLE: begin
                    tx_out <= 1'b1;
                    if (txEn_in && fifoOutReady_in) begin
                        state          <= REQ;
                        fifoReadEn_out <= 1'b1;
                        busy_out       <= 1'b1;
                    end
                end
                REQ: begin
                    // FIFO data appears on the following cycle
                    state <= LOAD;
                end
                LOAD: begin
                    shift_reg  <= fifoData_in;
                    parity_bit <= ^fifoData_in;
                    tx_out     <= 1'b0;
                    state      <= START;
                end
                START: begin
                    if (baud_tick) begin
                        tx_out    <= shift_reg[0];
                        shift_reg <= {1'b0, shift_reg[WORD_SIZE-1:1]};
                        bit_idx   <= '0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        if (bit_idx == IDX_W'(WORD_SIZE - 1)) begin
                            bit_idx <= '0;
                            if (PARITY_EN != 0) begin
                                tx_out <= parity_bit;
                                state  <= PARITY;
                            end else begin
                                tx_out <= 1'b1;
                                state  <= STOP;
                            end
                        end else begin
                            bit_idx   <= bit_idx + IDX_W'(1);
                            tx_out    <= shift_reg[0];
                            shift_reg <= {1'b0, shift_reg[WORD_SIZE-1:1]};
                        end
                    end
                end
                PARITY: begin
                    if (baud_tick) begin
                        tx_out <= 1'b1;
                        state  <= STOP;
                    end
                end
                STOP: begin
                    // Registered pulse lands on the final stop-bit cycle
                    if (baud_count == CNT_W'(CLKS_PER_BIT - 2)) begin
                        done_out <= 1'b1;
                    end
                    if (baud_tick) begin
                        busy_out <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    tx_out   <= 1'b1;
                    busy_out <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule : uart_tx
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx (CLKS_PER_BIT=4, WORD_SIZE=8).
//               dut0 has parity disabled, dut1 enabled; a small FIFO model
//               feeds whichever one sel points at.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       sel = 1'b0;
    logic [7:0] fifo_data = 8'h00;
    logic       ready0, ready1;
    logic       rd0, rd1, tx0, tx1, busy0, busy1, done0, done1;
    logic       rd_sel, tx_sel, busy_sel, done_sel;

    logic [7:0] qmem [0:63];
    int         qhead = 0;
    int         qtail = 0;
    int         rd_count = 0;
    int         done_count = 0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    assign ready0   = (sel == 1'b0) && (qhead != qtail);
    assign ready1   = (sel == 1'b1) && (qhead != qtail);
    assign rd_sel   = sel ? rd1   : rd0;
    assign tx_sel   = sel ? tx1   : tx0;
    assign busy_sel = sel ? busy1 : busy0;
    assign done_sel = sel ? done1 : done0;

    uart_tx #(.WORD_SIZE(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0)) dut0 (
        .clk_in(clk), .rst_in(rst), .txEn_in(en), .fifoOutReady_in(ready0),
        .fifoData_in(fifo_data), .fifoReadEn_out(rd0), .tx_out(tx0),
        .busy_out(busy0), .done_out(done0));

    uart_tx #(.WORD_SIZE(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1)) dut1 (
        .clk_in(clk), .rst_in(rst), .txEn_in(en), .fifoOutReady_in(ready1),
        .fifoData_in(fifo_data), .fifoReadEn_out(rd1), .tx_out(tx1),
        .busy_out(busy1), .done_out(done1));

    // FIFO with registered read data
    always @(posedge clk) begin
        if (rd_sel && (qhead != qtail)) begin
            fifo_data <= qmem[qhead];
            qhead     <= qhead + 1;
        end
    end

    // Strobe and pulse counters (both DUTs, so stray strobes are seen)
    always @(negedge clk) begin
        if (rd0 | rd1)     rd_count   <= rd_count + 1;
        if (done0 | done1) done_count <= done_count + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] w);
        qmem[qtail] = w;
        qtail = qtail + 1;
    endtask

    // Negedges until tx is first seen low; 0 if it never falls
    task automatic wait_fall(output int lat);
        lat = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (tx_sel === 1'b0) begin
                lat = i;
                break;
            end
        end
    endtask

    // Called on the first low cycle; samples each bit mid-period
    task automatic capture_rest(input int nbits, output logic [10:0] line,
                                output int done_at, output int unstable);
        logic prev;
        line = '0; done_at = 0; unstable = 0; prev = 1'b0;
        for (int c = 0; c < nbits * CPB; c++) begin
            if (c > 0) @(negedge clk);
            if (c % CPB == 0) prev = tx_sel;
            else if (tx_sel !== prev) unstable++;
            if (c % CPB == 2) line[c / CPB] = tx_sel;
            if (done_sel === 1'b1) begin
                if (done_at == 0) done_at = c + 1;
                else unstable++;
            end
        end
    endtask

    typedef struct {
        logic [7:0]  word;
        logic        par;
        int          nbits;
        logic [10:0] line;     // line[0]=start ... line[nbits-1]=stop
        int          done_at;  // 1-based cycle of done pulse from tx falling
    } vec_t;

    vec_t        vecs [6];
    logic [7:0]  bb_word [3];
    logic [10:0] bb_line [3];
    int          bb_lat  [3];

    initial begin
        int          lat, done_at, unstable, r0, d0, bad;
        logic [10:0] line;

        vecs[0] = '{8'hA5, 1'b0, 10, 11'b01101001010, 40};
        vecs[1] = '{8'h07, 1'b1, 11, 11'b11000001110, 44};
        vecs[2] = '{8'h00, 1'b0, 10, 11'b01000000000, 40};
        vecs[3] = '{8'hFF, 1'b1, 11, 11'b10111111110, 44};
        vecs[4] = '{8'h3C, 1'b0, 10, 11'b01001111000, 40};
        vecs[5] = '{8'h80, 1'b1, 11, 11'b11100000000, 44};

        bb_word[0] = 8'h00; bb_line[0] = 11'b01000000000; bb_lat[0] = 3;
        bb_word[1] = 8'hFF; bb_line[1] = 11'b01111111110; bb_lat[1] = 4;
        bb_word[2] = 8'h3C; bb_line[2] = 11'b01001111000; bb_lat[2] = 4;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_tx",   {31'd0, tx0},   32'd1);
        check("reset_busy", {31'd0, busy0}, 32'd0);
        check("reset_rd",   {31'd0, rd0},   32'd0);
        check("reset_done", {31'd0, done0}, 32'd0);
        rst = 1'b0;
        en  = 1'b1;

        // Empty FIFO for 100 cycles
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || busy0 !== 1'b0 || rd0 !== 1'b0) bad++;
        end
        check("idle_outputs", bad, 0);
        check("idle_reads", rd_count, 0);

        // Single frames, both parity settings
        for (int v = 0; v < 6; v++) begin
            sel = vecs[v].par;
            r0  = rd_count;
            push(vecs[v].word);
            wait_fall(lat);
            check($sformatf("v%0d_latency", v), lat, 3);
            check($sformatf("v%0d_busy", v), {31'd0, busy_sel}, 32'd1);
            capture_rest(vecs[v].nbits, line, done_at, unstable);
            check($sformatf("v%0d_line", v), {21'd0, line}, {21'd0, vecs[v].line});
            check($sformatf("v%0d_done_at", v), done_at, vecs[v].done_at);
            check($sformatf("v%0d_bit_hold", v), unstable, 0);
            repeat (6) @(negedge clk);
            check($sformatf("v%0d_reads", v), rd_count - r0, 1);
            check($sformatf("v%0d_idle_busy", v), {31'd0, busy_sel}, 32'd0);
        end

        // Three words back to back
        sel = 1'b0;
        r0  = rd_count;
        d0  = done_count;
        for (int i = 0; i < 3; i++) push(bb_word[i]);
        for (int i = 0; i < 3; i++) begin
            wait_fall(lat);
            check($sformatf("bb%0d_latency", i), lat, bb_lat[i]);
            capture_rest(10, line, done_at, unstable);
            check($sformatf("bb%0d_line", i), {21'd0, line}, {21'd0, bb_line[i]});
            check($sformatf("bb%0d_byte", i), {24'd0, line[8:1]}, {24'd0, bb_word[i]});
        end
        repeat (6) @(negedge clk);
        check("bb_reads", rd_count - r0, 3);
        check("bb_dones", done_count - d0, 3);

        // Reset during data bit 3
        d0 = done_count;
        push(8'hA5);
        wait_fall(lat);
        check("rst_mid_latency", lat, 3);
        repeat (17) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_tx",   {31'd0, tx0},   32'd1);
        check("rst_mid_busy", {31'd0, busy0}, 32'd0);
        rst = 1'b0;
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx0 !== 1'b1 || busy0 !== 1'b0) bad++;
        end
        check("rst_mid_quiet", bad, 0);
        check("rst_mid_no_done", done_count - d0, 0);

        // Enable dropped during START with data still queued
        r0 = rd_count;
        push(8'h5A);
        push(8'hC3);
        wait_fall(lat);
        en = 1'b0;
        capture_rest(10, line, done_at, unstable);
        check("en_drop_line", {21'd0, line}, {21'd0, 11'b01010110100});
        check("en_drop_done_at", done_at, 40);
        repeat (50) @(negedge clk);
        check("en_drop_reads", rd_count - r0, 1);
        check("en_drop_busy", {31'd0, busy0}, 32'd0);
        check("en_drop_tx", {31'd0, tx0}, 32'd1);

        // Re-enable: held word goes out
        en = 1'b1;
        wait_fall(lat);
        check("reen_latency", lat, 3);
        capture_rest(10, line, done_at, unstable);
        check("reen_line", {21'd0, line}, {21'd0, 11'b01110000110});
        repeat (6) @(negedge clk);
        check("reen_reads", rd_count - r0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_uart_tx
`default_nettype wire
